// File: rtl/logic_pipe.sv
// Bitwise-logic unit followed by an elastic valid/ready pipeline of STAGES slots.
// Bubbles collapse under backpressure; en freezes everything; done_cnt counts output transfers.
module logic_pipe #(
  parameter int BITS     = 4,
  parameter int STAGES   = 2,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [BITS-1:0]     foo,
  input  logic [BITS-1:0]     bar,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITS-1:0]     result,
  output logic                zero,
  output logic [CNT_BITS-1:0] done_cnt
);

  logic [BITS-1:0]     w_alu;
  logic                w_alu_zero;
  logic [STAGES-1:0]   w_vld;
  logic [STAGES-1:0]   w_zero;
  logic [BITS-1:0]     w_res [STAGES];
  logic [STAGES-1:0]   w_adv;
  logic                w_open;
  logic                w_in_xfer;
  logic [CNT_BITS-1:0] r_done;

  always_comb begin
    w_alu = '0;
    case (op)
      3'b000:  w_alu = foo & bar;
      3'b001:  w_alu = foo | bar;
      3'b010:  w_alu = foo ^ bar;
      3'b011:  w_alu = ~(foo & bar);
      3'b100:  w_alu = ~(foo | bar);
      3'b101:  w_alu = ~(foo ^ bar);
      3'b110:  w_alu = foo;
      default: w_alu = ~foo;
    endcase
  end

  assign w_alu_zero = (w_alu == '0);

  // Walk from the output back: a stage moves if the slot ahead is free or moving.
  // After the loop w_open tells whether stage 0 can take a new operand.
  always_comb begin
    w_open = out_ready;
    w_adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = en & w_vld[k] & w_open;
      w_open   = ~w_vld[k] | w_open;
    end
  end

  assign in_ready  = n_rst & en & w_open;
  assign w_in_xfer = in_valid & in_ready;
  assign out_valid = en & w_vld[STAGES-1];
  assign result    = w_res[STAGES-1];
  assign zero      = w_zero[STAGES-1];
  assign done_cnt  = r_done;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic            w_ld;
    logic [BITS-1:0] w_src_res;
    logic            w_src_zero;
    logic            r_vld;
    logic [BITS-1:0] r_res;
    logic            r_zero;

    if (g == 0) begin : g_head
      assign w_ld       = w_in_xfer;
      assign w_src_res  = w_alu;
      assign w_src_zero = w_alu_zero;
    end else begin : g_tail
      assign w_ld       = w_adv[g-1];
      assign w_src_res  = w_res[g-1];
      assign w_src_zero = w_zero[g-1];
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_vld  <= 1'b0;
        r_res  <= '0;
        r_zero <= 1'b0;
      end else if (w_ld) begin
        r_vld  <= 1'b1;
        r_res  <= w_src_res;
        r_zero <= w_src_zero;
      end else if (w_adv[g]) begin
        r_vld  <= 1'b0;
      end
    end

    assign w_vld[g]  = r_vld;
    assign w_res[g]  = r_res;
    assign w_zero[g] = r_zero;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_done <= '0;
    else if (w_adv[STAGES-1]) r_done <= r_done + CNT_BITS'(1);
  end

endmodule

// File: tb/tb_logic_pipe.sv
// Directed bench for logic_pipe: op table, backpressure, enable freeze, mid-flight reset, counter wrap.
module tb_logic_pipe;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       en = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'b000;
  logic [3:0] foo = '0;
  logic [3:0] bar = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] result;
  logic       zero;
  logic [7:0] done_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] items [256];

  typedef struct {
    logic [2:0] op;
    logic [3:0] foo;
    logic [3:0] bar;
    logic [3:0] res;
    logic       zero;
  } vec_t;

  vec_t vecs [10];

  logic_pipe #(.BITS(4), .STAGES(2), .CNT_BITS(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .foo       (foo),
    .bar       (bar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    en        = 1'b1;
    n_rst     = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  // Streams items[0..n-1] as pass-foo ops; out_ready / en are dropped over the given cycle windows.
  task automatic run(input int n, input int ro_s, input int ro_l, input int en_s, input int en_l);
    int sent = 0;
    int got = 0;
    int occ = 0;
    int c = 0;
    logic acc, emit, stall_prev;
    logic [3:0] res_prev;
    stall_prev = 1'b0;
    res_prev = '0;
    op  = 3'b110;
    bar = 4'b0000;
    while (got < n && c < 2000) begin
      en        = !(c >= en_s && c < en_s + en_l);
      out_ready = !(c >= ro_s && c < ro_s + ro_l);
      in_valid  = (sent < n);
      foo       = (sent < n) ? items[sent] : 4'b0000;
      #1;
      chk("in_ready", {31'b0, in_ready}, {31'b0, en && (occ < 2 || out_ready)});
      if (!en || occ == 0) chk("out_valid_idle", {31'b0, out_valid}, 32'd0);
      if (stall_prev && out_valid) chk("stall_hold", {28'b0, result}, {28'b0, res_prev});
      chk("done_cnt_run", {24'b0, done_cnt}, {24'b0, got[7:0]});
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        chk("order", {28'b0, result}, {28'b0, items[got]});
        got++;
      end
      stall_prev = out_valid && !out_ready;
      res_prev   = result;
      occ = occ + int'(acc) - int'(emit);
      if (acc) sent++;
      @(posedge clk);
      #1;
      c++;
    end
    chk("stream_complete", got, n);
    chk("done_cnt_end", {24'b0, done_cnt}, {24'b0, n[7:0]});
    in_valid  = 1'b0;
    en        = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 4'b1100, 4'b1010, 4'b1000, 1'b0};
    vecs[1] = '{3'b001, 4'b1100, 4'b1010, 4'b1110, 1'b0};
    vecs[2] = '{3'b010, 4'b1100, 4'b1010, 4'b0110, 1'b0};
    vecs[3] = '{3'b011, 4'b1100, 4'b1010, 4'b0111, 1'b0};
    vecs[4] = '{3'b100, 4'b1100, 4'b1010, 4'b0001, 1'b0};
    vecs[5] = '{3'b101, 4'b1100, 4'b1010, 4'b1001, 1'b0};
    vecs[6] = '{3'b110, 4'b1100, 4'b1010, 4'b1100, 1'b0};
    vecs[7] = '{3'b111, 4'b1100, 4'b1010, 4'b0011, 1'b0};
    vecs[8] = '{3'b110, 4'b0000, 4'b1010, 4'b0000, 1'b1};
    vecs[9] = '{3'b000, 4'b0101, 4'b1010, 4'b0000, 1'b1};

    // Reset state, with en high so in_ready is forced low by reset alone.
    n_rst = 1'b0;
    en    = 1'b1;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready}, 32'd0);
    chk("rst_result",    {28'b0, result}, 32'd0);
    chk("rst_zero",      {31'b0, zero}, 32'd0);
    chk("rst_done_cnt",  {24'b0, done_cnt}, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // Op table: one isolated transaction each, latency and counter checked.
    for (int i = 0; i < 10; i++) begin
      op = vecs[i].op; foo = vecs[i].foo; bar = vecs[i].bar;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("vec_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("vec_lat1_out_valid", {31'b0, out_valid}, 32'd0);
      tick();
      chk("vec_out_valid", {31'b0, out_valid}, 32'd1);
      chk("vec_result", {28'b0, result}, {28'b0, vecs[i].res});
      chk("vec_zero", {31'b0, zero}, {31'b0, vecs[i].zero});
      tick();
      chk("vec_drained", {31'b0, out_valid}, 32'd0);
      chk("vec_done_cnt", {24'b0, done_cnt}, i + 1);
    end

    // Backpressure after the first output: pipeline fills, then drains in order.
    do_reset();
    for (int i = 0; i < 5; i++) items[i] = 4'(i + 1);
    run(5, 3, 5, 0, 0);

    // Enable low for 3 cycles mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) items[i] = 4'(9 + i);
    run(5, 0, 0, 3, 3);

    // Reset with two results in flight (done_cnt is 5 here).
    op = 3'b110; bar = 4'b0000; out_ready = 1'b0;
    foo = 4'b1111; in_valid = 1'b1;
    tick();
    foo = 4'b1110;
    tick();
    in_valid = 1'b0;
    chk("flight_out_valid", {31'b0, out_valid}, 32'd1);
    chk("flight_result", {28'b0, result}, 32'hf);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready",  {31'b0, in_ready}, 32'd0);
    chk("arst_result",    {28'b0, result}, 32'd0);
    chk("arst_zero",      {31'b0, zero}, 32'd0);
    chk("arst_done_cnt",  {24'b0, done_cnt}, 32'd0);
    #3;
    n_rst = 1'b1;
    tick();
    out_ready = 1'b1;
    chk("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
    foo = 4'b0110; in_valid = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("post_rst_lat1", {31'b0, out_valid}, 32'd0);
    tick();
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_result", {28'b0, result}, 32'h6);
    tick();
    chk("post_rst_done_cnt", {24'b0, done_cnt}, 32'd1);
    chk("post_rst_drained", {31'b0, out_valid}, 32'd0);

    // 256 transfers: counter wraps to 0.
    do_reset();
    for (int i = 0; i < 256; i++) items[i] = 4'(i * 7);
    run(256, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
